// File: rtl/ps2_seg_scan_ctrl_if.sv
// Byte stream from the PS/2 receiver plus the link to the shared scancode->7-seg decoder.
interface ps2_seg_scan_ctrl_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic [7:0] dec_code;
    logic [6:0] dec_seg;

    modport master (output code_in, output code_valid, output dec_seg, input dec_code);
    modport slave  (input code_in, input code_valid, input dec_seg, output dec_code);
endinterface

// File: rtl/ps2_seg_scan_ctrl.sv
// PS/2 make-code parser feeding a shift buffer that is scanned onto multiplexed 7-seg digits.
// Optional macro REPEAT_FILTER_EN suppresses typematic repeats of the newest held key.
module ps2_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DIV_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    ps2_seg_scan_ctrl_if.slave     bus,
    output logic [6:0]             seg_out,
    output logic [NUM_DIGITS-1:0]  digit_en,
    output logic                   new_key
);

    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]  CODE_BRK = 8'hF0;
    localparam logic [7:0]  CODE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               push_c;
    logic               repeat_c;
    logic [7:0]         code_buf [NUM_DIGITS];
    logic [DIV_W-1:0]   div_q;
    logic [IDX_W-1:0]   idx_q;

    // Parser state register; clear behaves like reset for the parser
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and push decision; only make codes seen in IDLE reach the buffer
    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        if (bus.code_valid && !clear) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.code_in == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else if (bus.code_in == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        push_c = !repeat_c;
                    end
                end
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT:     state_d = (bus.code_in == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

`ifdef REPEAT_FILTER_EN
    logic held_q;

    // Held-key flag: set by a push, dropped once any break sequence starts
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            held_q <= 1'b0;
        end else if (push_c) begin
            held_q <= 1'b1;
        end else if (state_d == ST_BRK || state_d == ST_EXT_BRK) begin
            held_q <= 1'b0;
        end
    end

    assign repeat_c = held_q && (bus.code_in == code_buf[0]);
`else
    assign repeat_c = 1'b0;
`endif

    // Display buffer: newest key on digit 0, oldest falls off the end
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                code_buf[k] <= 8'h00;
            end
        end else if (push_c) begin
            for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
                code_buf[k] <= code_buf[k-1];
            end
            code_buf[0] <= bus.code_in;
        end
    end

    // Refresh divider and digit index; unaffected by clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign bus.dec_code = code_buf[idx_q];

    // Segments and enable are registered from the same index so they stay aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out  <= 7'h7F;
            digit_en <= '1;
            new_key  <= 1'b0;
        end else begin
            seg_out  <= bus.dec_seg;
            digit_en <= ~(NUM_DIGITS'(1) << idx_q);
            new_key  <= push_c;
        end
    end

endmodule

// File: tb/tb_ps2_seg_scan_ctrl.sv
// Bench for ps2_seg_scan_ctrl: byte-level key model plus cycle-count scan model, checked every cycle.
module tb_ps2_seg_scan_ctrl;

`ifdef REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg_out;
    logic [3:0] digit_en;
    logic       new_key;

    ps2_seg_scan_ctrl_if bus_if ();

    ps2_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .DIV_W       (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .bus      (bus_if.slave),
        .seg_out  (seg_out),
        .digit_en (digit_en),
        .new_key  (new_key)
    );

    always #5 clk = ~clk;

    // Stand-in for the external scancode decoder
    function automatic logic [6:0] seg_lut(input logic [7:0] c);
        case (c)
            8'h00:   return 7'h7F;
            8'h16:   return 7'b1111001;
            8'h1E:   return 7'b0100100;
            8'h26:   return 7'b0110000;
            8'h25:   return 7'b0011001;
            8'h1C:   return 7'b0001000;
            8'h24:   return 7'b0000110;
            default: return c[6:0] ^ 7'h55;
        endcase
    endfunction

    assign bus_if.dec_seg = seg_lut(bus_if.dec_code);

    int nchk = 0;
    int nbad = 0;
    int nk   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: displayed keys as an array, break/extended handling as "swallow next byte" flags
    logic [7:0] mbuf [4];
    bit         swallow, ext_pend, held, e_valid;
    int         t, sidx, pushes;
    logic [6:0] e_seg;
    logic [3:0] e_en;
    logic       e_nk;
    logic [7:0] b;

    initial begin
        e_valid = 1'b0;
        pushes  = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) mbuf[k] = 8'h00;
                swallow = 1'b0; ext_pend = 1'b0; held = 1'b0; t = 0;
                e_seg = 7'h7F; e_en = 4'hF; e_nk = 1'b0;
            end else begin
                sidx  = (t / 4) % 4;
                e_seg = seg_lut(mbuf[sidx]);
                e_en  = ~(4'b0001 << sidx);
                e_nk  = 1'b0;
                t++;
                if (clear) begin
                    for (int k = 0; k < 4; k++) mbuf[k] = 8'h00;
                    swallow = 1'b0; ext_pend = 1'b0; held = 1'b0;
                end else if (bus_if.code_valid) begin
                    b = bus_if.code_in;
                    if (swallow) begin
                        if (ext_pend && b == 8'hF0) begin
                            ext_pend = 1'b0; held = 1'b0;
                        end else begin
                            swallow = 1'b0; ext_pend = 1'b0;
                        end
                    end else if (b == 8'hF0) begin
                        swallow = 1'b1; held = 1'b0;
                    end else if (b == 8'hE0) begin
                        swallow = 1'b1; ext_pend = 1'b1;
                    end else if (!(FILTER && held && b == mbuf[0])) begin
                        for (int k = 3; k > 0; k--) mbuf[k] = mbuf[k-1];
                        mbuf[0] = b;
                        held = 1'b1;
                        e_nk = 1'b1;
                        pushes++;
                    end
                end
            end
            e_valid = 1'b1;
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (e_valid) begin
                chk("seg_out", 32'(seg_out), 32'(e_seg));
                chk("digit_en", 32'(digit_en), 32'(e_en));
                chk("new_key", 32'(new_key), 32'(e_nk));
                chk("dec_code", 32'(bus_if.dec_code), 32'(mbuf[(t / 4) % 4]));
                if (new_key) nk++;
            end
        end
    end

    task automatic send(input logic [7:0] c);
        bus_if.code_in    = c;
        bus_if.code_valid = 1'b1;
        @(negedge clk);
        bus_if.code_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(input logic [3:0] want);
        int i;
        for (i = 0; i < 40; i++) begin
            if (digit_en == want) break;
            @(negedge clk);
        end
        if (i == 40) chk("wait_en_timeout", 32'(digit_en), 32'(want));
    endtask

    logic [3:0] en_seq [4];

    initial begin
        en_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bus_if.code_in    = 8'h00;
        bus_if.code_valid = 1'b0;
        idle(3);
        chk("rst_seg", 32'(seg_out), 32'h7F);
        chk("rst_en", 32'(digit_en), 32'hF);
        chk("rst_nk", 32'(new_key), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("scan_seq", 32'(digit_en), 32'(en_seq[((k - 1) / 4) % 4]));
        end

        // Four make codes fill the buffer
        nk = 0;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        idle(2);
        chk("fill_nk", 32'(nk), 32'd4);
        chk("fill_b0", 32'(mbuf[0]), 32'h25);
        chk("fill_b1", 32'(mbuf[1]), 32'h26);
        chk("fill_b2", 32'(mbuf[2]), 32'h1E);
        chk("fill_b3", 32'(mbuf[3]), 32'h16);
        wait_en(4'b1101);
        wait_en(4'b1110);
        chk("digit0_seg", 32'(seg_out), 32'(7'b0011001));

        // Make then break of the same key
        nk = 0;
        send(8'h1C); send(8'hF0); send(8'h1C);
        idle(2);
        chk("brk_nk", 32'(nk), 32'd1);
        chk("brk_b0", 32'(mbuf[0]), 32'h1C);
        chk("brk_b1", 32'(mbuf[1]), 32'h25);

        // Extended make/break hidden, next plain key shown
        nk = 0;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h24);
        idle(2);
        chk("ext_nk", 32'(nk), 32'd1);
        chk("ext_b0", 32'(mbuf[0]), 32'h24);
        chk("ext_b1", 32'(mbuf[1]), 32'h1C);

        // Clear wins over a same-cycle byte
        nk = 0;
        clear = 1'b1;
        send(8'h16);
        clear = 1'b0;
        idle(1);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("clear_blank", 32'(seg_out), 32'h7F);
        end
        chk("clear_nk", 32'(nk), 32'd0);
        chk("clear_b0", 32'(mbuf[0]), 32'h00);

        // Typematic repeats
        nk = 0;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        idle(2);
        chk("repeat_nk", 32'(nk), FILTER ? 32'd2 : 32'd4);
        chk("repeat_b0", 32'(mbuf[0]), 32'h1C);
        chk("repeat_b1", 32'(mbuf[1]), FILTER ? 32'h1C : 32'h1C);
        chk("repeat_b2", 32'(mbuf[2]), FILTER ? 32'h00 : 32'h1C);

        // Double F0: second F0 is the discarded byte, next key shows
        nk = 0;
        send(8'hF0); send(8'hF0); send(8'h16);
        idle(2);
        chk("dbl_brk_nk", 32'(nk), 32'd1);
        chk("dbl_brk_b0", 32'(mbuf[0]), 32'h16);

        // Reset mid-sequence drops the pending E0
        send(8'hE0);
        rst_n = 1'b0;
        idle(1);
        chk("midrst_en", 32'(digit_en), 32'hF);
        rst_n = 1'b1;
        nk = 0;
        send(8'h24);
        idle(2);
        chk("midrst_nk", 32'(nk), 32'd1);
        chk("midrst_b0", 32'(mbuf[0]), 32'h24);
        chk("midrst_b1", 32'(mbuf[1]), 32'h00);
        idle(20);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
